// File: rtl/netcope_remover.sv
// rtl/netcope_remover.sv - strips the NetCOPE header part from FrameLink frames (optional header export: NETCOPE_REMOVER_HDR_OUT_EN)
module netcope_remover #(
  parameter int DATA_WIDTH = 128,
  parameter int REM_WIDTH  = $clog2(DATA_WIDTH / 8),
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic [REM_WIDTH-1:0]  RX_REM,
  input  logic                  RX_SOF_N,
  input  logic                  RX_EOF_N,
  input  logic                  RX_SOP_N,
  input  logic                  RX_EOP_N,
  input  logic                  RX_SRC_RDY_N,
  output logic                  RX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic [REM_WIDTH-1:0]  TX_REM,
  output logic                  TX_SOF_N,
  output logic                  TX_EOF_N,
  output logic                  TX_SOP_N,
  output logic                  TX_EOP_N,
  output logic                  TX_SRC_RDY_N,
  input  logic                  TX_DST_RDY_N,
  output logic [CNT_WIDTH-1:0]  FRAME_CNT,
  output logic [CNT_WIDTH-1:0]  ERR_CNT
`ifdef NETCOPE_REMOVER_HDR_OUT_EN
  ,
  output logic [DATA_WIDTH-1:0] HDR_DATA,
  output logic                  HDR_VLD
`endif
);

  localparam logic [1:0] S_HDR     = 2'd0;
  localparam logic [1:0] S_FIRST   = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [REM_WIDTH-1:0]  out_rem_q, out_rem_d;
  logic                  out_sof_n_q, out_sof_n_d;
  logic                  out_eof_n_q, out_eof_n_d;
  logic                  out_sop_n_q, out_sop_n_d;
  logic                  out_eop_n_q, out_eop_n_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

  logic rx_rdy;
  logic rx_acc;
  logic tx_xfer;

  // Incoming SOF is never trusted: the output SOF is regenerated from the FSM.
  logic unused_rx_sof_n;
  assign unused_rx_sof_n = RX_SOF_N;

`ifdef NETCOPE_REMOVER_HDR_OUT_EN
  logic [DATA_WIDTH-1:0] hdr_data_q, hdr_data_d;
  logic                  hdr_vld_q, hdr_vld_d;
  logic                  hdr_first_q, hdr_first_d;
`endif

  // Handshake: header words bypass the output register, so S_HDR never stalls RX.
  always_comb begin
    rx_rdy  = (state_q == S_HDR) || !out_vld_q || !TX_DST_RDY_N;
    rx_acc  = !RX_SRC_RDY_N && rx_rdy;
    tx_xfer = out_vld_q && !TX_DST_RDY_N;
  end

  // Next-state: frame parsing FSM, output register load/drain and statistics.
  always_comb begin
    state_d     = state_q;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_rem_d   = out_rem_q;
    out_sof_n_d = out_sof_n_q;
    out_eof_n_d = out_eof_n_q;
    out_sop_n_d = out_sop_n_q;
    out_eop_n_d = out_eop_n_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    // A drained register empties; a load below in the same cycle refills it.
    if (tx_xfer) begin
      out_vld_d = 1'b0;
    end

    case (state_q)
      S_HDR: begin
        // Header words are dropped without touching a pending output word.
        if (rx_acc && !RX_EOP_N) begin
          if (!RX_EOF_N) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
          end else begin
            state_d = S_FIRST;
          end
        end
      end
      S_FIRST, S_PAYLOAD: begin
        if (rx_acc) begin
          out_vld_d   = 1'b1;
          out_data_d  = RX_DATA;
          out_rem_d   = RX_REM;
          out_eof_n_d = RX_EOF_N;
          out_eop_n_d = RX_EOP_N;
          // The first payload word becomes the new start of frame and part.
          out_sof_n_d = (state_q == S_FIRST) ? 1'b0 : 1'b1;
          out_sop_n_d = (state_q == S_FIRST) ? 1'b0 : RX_SOP_N;
          state_d     = S_PAYLOAD;
          if (!RX_EOF_N) begin
            frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
            state_d     = S_HDR;
          end
        end
      end
      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  // State and output register, cleared asynchronously so a pending word is lost on reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_HDR;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_rem_q   <= '0;
      out_sof_n_q <= 1'b1;
      out_eof_n_q <= 1'b1;
      out_sop_n_q <= 1'b1;
      out_eop_n_q <= 1'b1;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_rem_q   <= out_rem_d;
      out_sof_n_q <= out_sof_n_d;
      out_eof_n_q <= out_eof_n_d;
      out_sop_n_q <= out_sop_n_d;
      out_eop_n_q <= out_eop_n_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

`ifdef NETCOPE_REMOVER_HDR_OUT_EN
  // Header export: capture the first header word, pulse valid when a payload follows.
  always_comb begin
    hdr_data_d  = hdr_data_q;
    hdr_first_d = hdr_first_q;
    hdr_vld_d   = 1'b0;
    if (rx_acc && (state_q == S_HDR)) begin
      if (hdr_first_q) begin
        hdr_data_d = RX_DATA;
      end
      // The word after a header EOP starts a new header on the next frame.
      hdr_first_d = !RX_EOP_N;
      hdr_vld_d   = !RX_EOP_N && RX_EOF_N;
    end
  end

  // Header export registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hdr_data_q  <= '0;
      hdr_vld_q   <= 1'b0;
      hdr_first_q <= 1'b1;
    end else begin
      hdr_data_q  <= hdr_data_d;
      hdr_vld_q   <= hdr_vld_d;
      hdr_first_q <= hdr_first_d;
    end
  end

  assign HDR_DATA = hdr_data_q;
  assign HDR_VLD  = hdr_vld_q;
`endif

  assign RX_DST_RDY_N = !rx_rdy;
  assign TX_SRC_RDY_N = !out_vld_q;
  assign TX_DATA      = out_data_q;
  assign TX_REM       = out_rem_q;
  assign TX_SOF_N     = out_sof_n_q;
  assign TX_EOF_N     = out_eof_n_q;
  assign TX_SOP_N     = out_sop_n_q;
  assign TX_EOP_N     = out_eop_n_q;
  assign FRAME_CNT    = frame_cnt_q;
  assign ERR_CNT      = err_cnt_q;

endmodule

// File: tb/tb_netcope_remover.sv
// tb/tb_netcope_remover.sv - table-driven and sequence bench for netcope_remover
module tb_netcope_remover;

  localparam int DW = 128;
  localparam int RW = 4;
  localparam int CW = 32;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [DW-1:0] RX_DATA;
  logic [RW-1:0] RX_REM;
  logic          RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N;
  logic          RX_SRC_RDY_N;
  logic          RX_DST_RDY_N;
  logic [DW-1:0] TX_DATA;
  logic [RW-1:0] TX_REM;
  logic          TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N;
  logic          TX_SRC_RDY_N;
  logic          TX_DST_RDY_N;
  logic [CW-1:0] FRAME_CNT;
  logic [CW-1:0] ERR_CNT;
`ifdef NETCOPE_REMOVER_HDR_OUT_EN
  logic [DW-1:0] HDR_DATA;
  logic          HDR_VLD;
`endif

  always #5 CLK = ~CLK;

  netcope_remover #(.DATA_WIDTH(DW), .REM_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .RX_DATA(RX_DATA), .RX_REM(RX_REM),
    .RX_SOF_N(RX_SOF_N), .RX_EOF_N(RX_EOF_N), .RX_SOP_N(RX_SOP_N), .RX_EOP_N(RX_EOP_N),
    .RX_SRC_RDY_N(RX_SRC_RDY_N), .RX_DST_RDY_N(RX_DST_RDY_N),
    .TX_DATA(TX_DATA), .TX_REM(TX_REM),
    .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N), .TX_SOP_N(TX_SOP_N), .TX_EOP_N(TX_EOP_N),
    .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N),
    .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT)
`ifdef NETCOPE_REMOVER_HDR_OUT_EN
    , .HDR_DATA(HDR_DATA), .HDR_VLD(HDR_VLD)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          src_n, sof_n, eof_n, sop_n, eop_n;
    logic [DW-1:0] data;
    logic [RW-1:0] rem;
    logic          txdst_n;
    logic          x_rxdst_n, x_txsrc_n;
    logic          x_sof_n, x_eof_n, x_sop_n, x_eop_n;
    logic [DW-1:0] x_data;
    logic [RW-1:0] x_rem;
    int            x_fcnt, x_ecnt;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [RW-1:0] rem;
    logic          sof_n, eof_n, sop_n, eop_n;
  } word_t;

  vec_t  vt[$];
  word_t inq[$];
  word_t expq[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic src_n, sof_n, eof_n, sop_n, eop_n,
                              input logic [DW-1:0] data, input logic [RW-1:0] rem,
                              input logic txdst_n, x_rxdst_n, x_txsrc_n,
                              input logic x_sof_n, x_eof_n, x_sop_n, x_eop_n,
                              input logic [DW-1:0] x_data, input logic [RW-1:0] x_rem,
                              input int x_fcnt, x_ecnt);
    vec_t v;
    v.src_n = src_n; v.sof_n = sof_n; v.eof_n = eof_n; v.sop_n = sop_n; v.eop_n = eop_n;
    v.data = data; v.rem = rem; v.txdst_n = txdst_n;
    v.x_rxdst_n = x_rxdst_n; v.x_txsrc_n = x_txsrc_n;
    v.x_sof_n = x_sof_n; v.x_eof_n = x_eof_n; v.x_sop_n = x_sop_n; v.x_eop_n = x_eop_n;
    v.x_data = x_data; v.x_rem = x_rem; v.x_fcnt = x_fcnt; v.x_ecnt = x_ecnt;
    return v;
  endfunction

  task automatic drive(input logic [DW-1:0] d, input logic [RW-1:0] r,
                       input logic sof_n, eof_n, sop_n, eop_n);
    RX_SRC_RDY_N = 1'b0;
    RX_DATA = d; RX_REM = r;
    RX_SOF_N = sof_n; RX_EOF_N = eof_n; RX_SOP_N = sop_n; RX_EOP_N = eop_n;
  endtask

  task automatic idle();
    RX_SRC_RDY_N = 1'b1;
    RX_SOF_N = 1'b1; RX_EOF_N = 1'b1; RX_SOP_N = 1'b1; RX_EOP_N = 1'b1;
  endtask

  // Presents a word and returns at edge+1 of the edge that accepted it.
  task automatic send_word(input string name, input logic [DW-1:0] d, input logic [RW-1:0] r,
                           input logic sof_n, eof_n, sop_n, eop_n);
    logic acc;
    drive(d, r, sof_n, eof_n, sop_n, eop_n);
    for (int i = 0; i < 50; i++) begin
      #1;
      acc = !RX_DST_RDY_N;
      @(posedge CLK); #1;
      if (acc) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_accept_timeout actual=not_accepted required=accepted", name);
  endtask

  logic [DW-1:0] hdr_a;
  logic [DW-1:0] rnd;
  int fstart, idx, bytes, nw;
  logic acc, take;

  initial begin
    hdr_a = {8{16'hAAAA}};
    RESET_N = 1'b0;
    RX_DATA = '0; RX_REM = '0;
    idle();
    TX_DST_RDY_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RESET_N = 1'b1;
    #1;
    chk("rst_txsrc", TX_SRC_RDY_N, 1'b1);
    chk("rst_txdata", TX_DATA, '0);
    chk("rst_txrem", TX_REM, '0);
    chk("rst_delims", {TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N}, 4'hF);
    chk("rst_fcnt", FRAME_CNT, 0);
    chk("rst_ecnt", ERR_CNT, 0);
    @(posedge CLK); #1;
    chk("rst_rxdst", RX_DST_RDY_N, 1'b0);

    // src sof eof sop eop data rem txdst | rxdst txsrc sof eof sop eop data rem fcnt ecnt
    vt.push_back(mk(0, 0,1,0,0, hdr_a,  0, 0,  0,1, 1,1,1,1, 0,     0, 0,0));
    vt.push_back(mk(0, 1,1,0,1, 128'h1, 15, 0, 0,0, 0,1,0,1, 128'h1,15, 0,0));
    vt.push_back(mk(0, 1,1,1,1, 128'h2, 15, 0, 0,0, 1,1,1,1, 128'h2,15, 0,0));
    vt.push_back(mk(0, 1,0,1,0, 128'h3, 5,  0, 0,0, 1,0,1,0, 128'h3,5,  1,0));
    vt.push_back(mk(1, 1,1,1,1, 0,      0,  0, 0,1, 1,1,1,1, 0,     0,  1,0));
    vt.push_back(mk(0, 0,0,0,0, {8{16'hBBBB}},0, 0, 0,1, 1,1,1,1, 0, 0, 1,1));
    vt.push_back(mk(1, 1,1,1,1, 0,      0,  0, 0,1, 1,1,1,1, 0,     0,  1,1));
    vt.push_back(mk(0, 0,1,0,0, {8{16'hCCCC}},0, 0, 0,1, 1,1,1,1, 0, 0, 1,1));
    vt.push_back(mk(0, 1,0,0,0, 128'h44, 7, 0, 0,0, 0,0,0,0, 128'h44,7, 2,1));
    vt.push_back(mk(0, 0,1,0,1, 128'h55, 0, 0, 0,1, 1,1,1,1, 0,      0, 2,1));
    vt.push_back(mk(0, 1,1,1,0, 128'h66, 0, 0, 0,1, 1,1,1,1, 0,      0, 2,1));
    vt.push_back(mk(0, 1,1,0,1, 128'h77, 15,0, 0,0, 0,1,0,1, 128'h77,15,2,1));
    vt.push_back(mk(0, 1,0,1,0, 128'h88, 3, 1, 1,0, 0,1,0,1, 128'h77,15,2,1));
    vt.push_back(mk(0, 1,0,1,0, 128'h88, 3, 0, 0,0, 1,0,1,0, 128'h88,3, 3,1));
    vt.push_back(mk(1, 1,1,1,1, 0,       0, 1, 0,0, 1,0,1,0, 128'h88,3, 3,1));
    vt.push_back(mk(0, 0,1,0,0, 128'h99, 0, 1, 0,0, 1,0,1,0, 128'h88,3, 3,1));
    vt.push_back(mk(0, 1,0,0,0, 128'hA1, 1, 1, 1,0, 1,0,1,0, 128'h88,3, 3,1));
    vt.push_back(mk(0, 1,0,0,0, 128'hA1, 1, 0, 0,0, 0,0,0,0, 128'hA1,1, 4,1));
    vt.push_back(mk(1, 1,1,1,1, 0,       0, 0, 0,1, 1,1,1,1, 0,      0, 4,1));

    foreach (vt[i]) begin
      RX_SRC_RDY_N = vt[i].src_n;
      RX_DATA = vt[i].data; RX_REM = vt[i].rem;
      RX_SOF_N = vt[i].sof_n; RX_EOF_N = vt[i].eof_n;
      RX_SOP_N = vt[i].sop_n; RX_EOP_N = vt[i].eop_n;
      TX_DST_RDY_N = vt[i].txdst_n;
      #1;
      chk($sformatf("v%0d_rxdst", i), RX_DST_RDY_N, vt[i].x_rxdst_n);
      @(posedge CLK); #1;
      chk($sformatf("v%0d_txsrc", i), TX_SRC_RDY_N, vt[i].x_txsrc_n);
      if (!vt[i].x_txsrc_n) begin
        chk($sformatf("v%0d_delims", i), {TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N},
            {vt[i].x_sof_n, vt[i].x_eof_n, vt[i].x_sop_n, vt[i].x_eop_n});
        chk($sformatf("v%0d_data", i), TX_DATA, vt[i].x_data);
        chk($sformatf("v%0d_rem", i), TX_REM, vt[i].x_rem);
      end
      chk($sformatf("v%0d_fcnt", i), FRAME_CNT, vt[i].x_fcnt);
      chk($sformatf("v%0d_ecnt", i), ERR_CNT, vt[i].x_ecnt);
    end
    TX_DST_RDY_N = 1'b0;
    idle();

    // 3-word header, 2-word payload, downstream stalled for 5 cycles.
    send_word("st_h0", 128'h10, 0, 0, 1, 0, 1);
    send_word("st_h1", 128'h11, 0, 1, 1, 1, 1);
    send_word("st_h2", 128'h12, 0, 1, 1, 1, 0);
    send_word("st_p1", 128'h20, 15, 1, 1, 0, 1);
    drive(128'h21, 9, 1, 0, 1, 0);
    TX_DST_RDY_N = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("st%0d_rxdst", c), RX_DST_RDY_N, 1'b1);
      chk($sformatf("st%0d_hold", c), {TX_SRC_RDY_N, TX_SOF_N, TX_DATA}, {1'b0, 1'b0, 128'h20});
      @(posedge CLK); #1;
    end
    TX_DST_RDY_N = 1'b0;
    #1;
    chk("st_release_rxdst", RX_DST_RDY_N, 1'b0);
    @(posedge CLK); #1;
    idle();
    chk("st_p2", {TX_SRC_RDY_N, TX_SOF_N, TX_EOF_N, TX_EOP_N, TX_REM, TX_DATA},
        {1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 128'h21});
    chk("st_fcnt", FRAME_CNT, 5);
    @(posedge CLK); #1;
    chk("st_drained", TX_SRC_RDY_N, 1'b1);

    // 10 back-to-back frames, random sizes, downstream throttled at 50%.
    for (int f = 0; f < 10; f++) begin
      word_t w;
      bytes = $urandom_range(1, 650);
      nw = (bytes + 15) / 16;
      rnd = {$urandom, $urandom, $urandom, $urandom};
      w.data = rnd; w.rem = 0; w.sof_n = 0; w.eof_n = 1; w.sop_n = 0; w.eop_n = 0;
      inq.push_back(w);
      for (int k = 0; k < nw; k++) begin
        rnd = {$urandom, $urandom, $urandom, $urandom};
        w.data  = rnd;
        w.rem   = (k == nw - 1) ? RW'((bytes - 1) % 16) : RW'(15);
        w.eof_n = !(k == nw - 1);
        w.eop_n = !(k == nw - 1);
        w.sop_n = (k != 0);
        w.sof_n = 1'b1;
        inq.push_back(w);
        w.sof_n = (k != 0);
        expq.push_back(w);
      end
    end
    fstart = FRAME_CNT;
    idx = 0;
    for (int c = 0; c < 20000 && expq.size() > 0; c++) begin
      TX_DST_RDY_N = 1'($urandom_range(0, 1));
      if (idx < inq.size())
        drive(inq[idx].data, inq[idx].rem, inq[idx].sof_n, inq[idx].eof_n,
              inq[idx].sop_n, inq[idx].eop_n);
      else
        idle();
      #1;
      acc  = !RX_SRC_RDY_N && !RX_DST_RDY_N;
      take = !TX_SRC_RDY_N && !TX_DST_RDY_N;
      if (take) begin
        chk("rnd_word", {TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N},
            {expq[0].data, expq[0].rem, expq[0].sof_n, expq[0].eof_n, expq[0].sop_n, expq[0].eop_n});
        void'(expq.pop_front());
      end
      @(posedge CLK); #1;
      if (acc) idx++;
    end
    chk("rnd_remaining", expq.size(), 0);
    chk("rnd_fcnt", FRAME_CNT, fstart + 10);
    idle();
    TX_DST_RDY_N = 1'b0;
    @(posedge CLK); #1;

    // Reset while a payload word is pending.
    send_word("rs_h", 128'h30, 0, 0, 1, 0, 0);
    send_word("rs_p", 128'h31, 15, 1, 1, 0, 1);
    idle();
    TX_DST_RDY_N = 1'b1;
    #2;
    RESET_N = 1'b0;
    #1;
    chk("rs_txsrc", TX_SRC_RDY_N, 1'b1);
    chk("rs_fcnt", FRAME_CNT, 0);
    chk("rs_ecnt", ERR_CNT, 0);
    @(negedge CLK) RESET_N = 1'b1;
    TX_DST_RDY_N = 1'b0;
    @(posedge CLK); #1;
    send_word("rs_h2", 128'hE0, 0, 0, 1, 0, 0);
    idle();
    #1;
    chk("rs_hdr_stripped", TX_SRC_RDY_N, 1'b1);
    send_word("rs_p2", 128'hF1, 2, 1, 0, 0, 0);
    idle();
    chk("rs_p2_out", {TX_SRC_RDY_N, TX_SOF_N, TX_EOF_N, TX_REM, TX_DATA},
        {1'b0, 1'b0, 1'b0, 4'd2, 128'hF1});
    chk("rs_p2_fcnt", FRAME_CNT, 1);
    @(posedge CLK); #1;

`ifdef NETCOPE_REMOVER_HDR_OUT_EN
    send_word("hd_h", {4{32'hDEADBEEF}}, 0, 0, 1, 0, 0);
    drive(128'h5A, 0, 1, 0, 0, 0);
    chk("hd_vld", HDR_VLD, 1'b1);
    chk("hd_data", HDR_DATA, {4{32'hDEADBEEF}});
    chk("hd_no_tx_yet", TX_SRC_RDY_N, 1'b1);
    @(posedge CLK); #1;
    idle();
    chk("hd_vld_pulse", HDR_VLD, 1'b0);
    chk("hd_payload_sof", {TX_SRC_RDY_N, TX_SOF_N, TX_DATA}, {1'b0, 1'b0, 128'h5A});
    chk("hd_data_hold", HDR_DATA, {4{32'hDEADBEEF}});
    @(posedge CLK); #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/netcope_remover.md
# netcope_remover

Strips the NetCOPE header part from FrameLink frames, the inverse of the NetCOPE adder. Each incoming frame carries the adder-inserted header as its first part, followed by one or more payload parts. The block discards the header part and re-marks the first payload part as start of frame. It sits on the receive path between the DMA/software-side FrameLink and the user application, with one registered output stage.

## Interface
- DATA_WIDTH, 128: FrameLink data width in bits, one of 32, 64 or 128.
- REM_WIDTH, log2(DATA_WIDTH/8): width of the REM field.
- CNT_WIDTH, 32: width of the statistics counters.

- CLK  in  1  clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- RX_DATA  in  DATA_WIDTH  input FrameLink data.
- RX_REM  in  REM_WIDTH  index of the last valid byte in an EOP word.
- RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  1 each  active-low frame/part delimiters.
- RX_SRC_RDY_N  in  1  input word valid, active-low.
- RX_DST_RDY_N  out  1  block ready to accept, active-low.
- TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  as RX  output FrameLink.
- TX_SRC_RDY_N  out  1  output word valid.
- TX_DST_RDY_N  in  1  downstream ready.
- FRAME_CNT  out  CNT_WIDTH  count of frames forwarded with payload.
- ERR_CNT  out  CNT_WIDTH  count of header-only frames dropped.

## Operation
- Transfer on a port occurs when SRC_RDY_N=0 and DST_RDY_N=0 in the same cycle.
- FSM states:
  - S_HDR (reset state). Every accepted word is discarded.
    - If the accepted word has RX_EOP_N=0 and RX_EOF_N=1, go to S_FIRST.
    - If RX_EOP_N=0 and RX_EOF_N=0, the frame is header-only. Drop it, increment ERR_CNT and stay in S_HDR.
  - S_FIRST. The first accepted word is forwarded with TX_SOF_N=0 and TX_SOP_N=0, and the next state is S_PAYLOAD.
    - If that word also has RX_EOF_N=0, increment FRAME_CNT and return to S_HDR.
  - S_PAYLOAD. Words are forwarded unchanged, except that TX_SOF_N is forced to 1.
    - On an accepted word with RX_EOF_N=0, increment FRAME_CNT and return to S_HDR.
- Input SOF_N and SOP_N on header words are not checked.
- An RX_SOF_N=0 word arriving in S_FIRST or S_PAYLOAD is forwarded as data. No resynchronisation is attempted.
- TX_DATA, TX_REM, TX_EOF_N, TX_SOP_N and TX_EOP_N are copied from RX in the forwarded word.
- Counters wrap from 2^CNT_WIDTH-1 to 0.
- Output register stage (one entry):
  - RX_DST_RDY_N=0 when the register is empty or TX_DST_RDY_N=0.
  - In S_HDR, RX_DST_RDY_N=0 unconditionally, because header words never occupy the register.
  - A discarded header word must not disturb a pending output word.

## Timing
- Latency is 1 cycle: a word accepted at edge n is presented on TX after edge n, and held until a TX transfer.
- Full throughput of one word per cycle holds when TX_DST_RDY_N=0 continuously.
- The header part costs its own word count in bubbles on TX and no stall on RX.
- Simultaneous TX transfer and RX accept in the same cycle: the register is reloaded with no bubble.
- Reset values:
  - TX_SRC_RDY_N=1, all TX delimiters=1, TX_DATA=0, TX_REM=0.
  - FSM=S_HDR, FRAME_CNT=0, ERR_CNT=0.
  - RX_DST_RDY_N=0 from the first edge after deassertion.
- Reset asserted mid-frame discards the pending output word immediately. The next frame is then parsed from S_HDR.

## Configuration
- NETCOPE_REMOVER_HDR_OUT_EN defined:
  - Adds ports HDR_DATA (out, DATA_WIDTH) and HDR_VLD (out, 1).
  - The first word of each header part is latched into HDR_DATA.
  - HDR_VLD pulses high for 1 cycle, in the cycle after the header EOP is accepted, for frames that have a payload.
  - HDR_DATA resets to 0 and holds its value between frames.
- Macro undefined: these ports and registers do not exist, and header contents are discarded.

## Test plan
- Frame with 1-word header (RX_DATA=0xAAAA…) and 3-word payload 0x1, 0x2, 0x3 (REM=5), TX always ready:
  - TX shows 0x1 (SOF_N=0, SOP_N=0), then 0x2, then 0x3 (EOF_N=0, EOP_N=0, REM=5) on consecutive cycles.
  - FRAME_CNT=1.
- Header-only frame (single word, SOP/EOP/SOF/EOF all 0):
  - No TX_SRC_RDY_N=0 ever; ERR_CNT=1; FRAME_CNT=0.
  - The next normal frame is forwarded correctly.
- 3-word header and 2-word payload, TX_DST_RDY_N=1 for 5 cycles after the first payload word:
  - TX holds the first payload word stable and RX_DST_RDY_N=1 during the stall.
  - No data is lost; FRAME_CNT=1.
- 10 back-to-back frames, header 1 word, payload sizes 1..650 bytes (random), TX randomly throttled at 50%:
  - Output byte stream matches the payloads in order; FRAME_CNT=10.
- RESET_N pulsed low in the middle of a payload:
  - TX_SRC_RDY_N=1 immediately and counters are 0.
  - The following frame's header is stripped.
- With NETCOPE_REMOVER_HDR_OUT_EN, header word 0xDEADBEEF_…:
  - HDR_VLD=1 for exactly one cycle and HDR_DATA=0xDEADBEEF_… before the payload SOF appears on TX.
